// File: rtl/ssem_seq_pkg.sv
// ssem_seq_pkg: op codes, FSM state, driver-select and strobe-select encodings shared by the SSEM bus sequencer
package ssem_seq_pkg;

    localparam logic [2:0] OP_LDA    = 3'd0;
    localparam logic [2:0] OP_LDB    = 3'd1;
    localparam logic [2:0] OP_STA    = 3'd2;
    localparam logic [2:0] OP_STB    = 3'd3;
    localparam logic [2:0] OP_ADD_ST = 3'd4;
    localparam logic [2:0] OP_SUB_ST = 3'd5;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_TURN} state_t;

    typedef enum logic [2:0] {DRV_NONE, DRV_A, DRV_B, DRV_ALU, DRV_MEM} drv_t;

    typedef enum logic [1:0] {STB_NONE, STB_A, STB_B, STB_WE} stb_t;

endpackage

// File: rtl/ssem_seq_decode.sv
// ssem_seq_decode: combinational op -> bus driver, strobe target, ALU mode and illegal flag
//   op      in   3-bit micro-command opcode
//   drv     out  which unit drives the bus for this op
//   stb     out  which latch/write strobe this op fires
//   sub     out  ALU subtract mode
//   illegal out  opcode 6 or 7
module ssem_seq_decode
    import ssem_seq_pkg::*;
(
    input  logic [2:0] op,
    output drv_t       drv,
    output stb_t       stb,
    output logic       sub,
    output logic       illegal
);

    always_comb begin
        illegal = op > OP_SUB_ST;
        drv     = illegal ? DRV_NONE :
                  (op == OP_STA) ? DRV_A :
                  (op == OP_STB) ? DRV_B :
                  (op == OP_ADD_ST || op == OP_SUB_ST) ? DRV_ALU : DRV_MEM;
        stb     = illegal ? STB_NONE :
                  (op == OP_LDA) ? STB_A :
                  (op == OP_LDB) ? STB_B : STB_WE;
        sub     = op == OP_SUB_ST;
    end

endmodule

// File: rtl/ssem_bus_sequencer.sv
// ssem_bus_sequencer: expands SSEM micro-commands into timed bus-driver enables and load/write strobes
//   clk, reset (async, active-high)
//   cmd_valid/cmd_ready/cmd_op/cmd_addr  command handshake
//   done, err                            completion / illegal-op pulses
//   load_A, load_B, mem_we               latch and store-write strobes
//   a_to_bus, b_to_bus, alu_to_bus, mem_to_bus, alu_sub, mem_addr  datapath controls
//   Build option: define SSEM_SEQ_PREFETCH_EN for a one-entry command buffer.
module ssem_bus_sequencer
    import ssem_seq_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned TURN_CYCLES   = 1,
    parameter int unsigned ADDR_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              done,
    output logic              err,
    output logic              load_A,
    output logic              load_B,
    output logic              a_to_bus,
    output logic              b_to_bus,
    output logic              alu_to_bus,
    output logic              alu_sub,
    output logic              mem_to_bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr
);

    state_t            state;
    logic [3:0]        cnt;
    stb_t              cur_stb;
    logic              launch;
    logic [2:0]        src_op;
    logic [ADDR_W-1:0] src_addr;
    drv_t              dec_drv;
    stb_t              dec_stb;
    logic              dec_sub;
    logic              dec_ill;

`ifdef SSEM_SEQ_PREFETCH_EN
    logic              buf_full;
    logic [2:0]        buf_op;
    logic [ADDR_W-1:0] buf_addr;

    // A buffered command launches from IDLE or straight out of the last TURN cycle.
    assign cmd_ready = !buf_full;
    assign launch    = (state == ST_IDLE && (buf_full || cmd_valid)) ||
                       (state == ST_TURN && cnt == 4'd0 && buf_full);
    assign src_op    = buf_full ? buf_op : cmd_op;
    assign src_addr  = buf_full ? buf_addr : cmd_addr;

    // Commands accepted in IDLE with an empty buffer bypass it and launch directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_op   <= '0;
            buf_addr <= '0;
        end else if (launch && buf_full) begin
            buf_full <= 1'b0;
        end else if (cmd_valid && cmd_ready && state != ST_IDLE) begin
            buf_full <= 1'b1;
            buf_op   <= cmd_op;
            buf_addr <= cmd_addr;
        end
    end
`else
    assign cmd_ready = state == ST_IDLE;
    assign launch    = cmd_valid && cmd_ready;
    assign src_op    = cmd_op;
    assign src_addr  = cmd_addr;
`endif

    ssem_seq_decode u_dec (
        .op      (src_op),
        .drv     (dec_drv),
        .stb     (dec_stb),
        .sub     (dec_sub),
        .illegal (dec_ill)
    );

    // Outputs are registered as the value they must hold in the state being entered,
    // so launches only happen where every driver and strobe is already low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cur_stb    <= STB_NONE;
            mem_addr   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            mem_we     <= 1'b0;
            a_to_bus   <= 1'b0;
            b_to_bus   <= 1'b0;
            alu_to_bus <= 1'b0;
            mem_to_bus <= 1'b0;
            alu_sub    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (launch) begin
                mem_addr   <= src_addr;
                cur_stb    <= dec_stb;
                err        <= dec_ill;
                state      <= dec_ill ? ST_IDLE : ST_SETUP;
                a_to_bus   <= dec_drv == DRV_A;
                b_to_bus   <= dec_drv == DRV_B;
                alu_to_bus <= dec_drv == DRV_ALU;
                mem_to_bus <= dec_drv == DRV_MEM;
                alu_sub    <= dec_sub;
            end else begin
                case (state)
                    ST_SETUP: begin
                        state  <= ST_STROBE;
                        cnt    <= 4'(STROBE_CYCLES - 1);
                        load_A <= cur_stb == STB_A;
                        load_B <= cur_stb == STB_B;
                        mem_we <= cur_stb == STB_WE;
                    end
                    ST_STROBE: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd0) begin
                            state  <= ST_HOLD;
                            load_A <= 1'b0;
                            load_B <= 1'b0;
                            mem_we <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        state      <= ST_TURN;
                        cnt        <= 4'(TURN_CYCLES - 1);
                        done       <= TURN_CYCLES == 1;
                        a_to_bus   <= 1'b0;
                        b_to_bus   <= 1'b0;
                        alu_to_bus <= 1'b0;
                        mem_to_bus <= 1'b0;
                        alu_sub    <= 1'b0;
                    end
                    ST_TURN: begin
                        cnt  <= cnt - 4'd1;
                        done <= cnt == 4'd1;
                        if (cnt == 4'd0) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ssem_bus_sequencer.md
Name: ssem_bus_sequencer

Overview:
- Control sequencer for the SSEM register/ALU datapath and the store.
- Accepts micro-commands over a valid/ready handshake.
- Expands each command into a timed sequence of driver enables and load/write strobes: load_A, load_B, a_to_bus, b_to_bus, alu_to_bus, alu_sub, mem_to_bus, mem_we.
- Guarantees at most one bus driver at any time and a dead turnaround cycle between drivers.

Parameters:
- STROBE_CYCLES, 1, width in clocks of the load_A/load_B/mem_we strobe; legal range 1..15.
- TURN_CYCLES, 1, clocks with no bus driver after each command; legal range 1..15.
- ADDR_W, 5, store address width (32-word store).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0=LDA, 1=LDB, 2=STA, 3=STB, 4=ADD_ST, 5=SUB_ST, 6..7 illegal.
- cmd_addr  in  ADDR_W  store address for the command.
- done  out  1  one-cycle pulse when a legal command completes.
- err  out  1  one-cycle pulse when an illegal op is accepted.
- load_A  out  1  register A latch enable.
- load_B  out  1  register B latch enable.
- a_to_bus  out  1  register A drives the bus.
- b_to_bus  out  1  register B drives the bus.
- alu_to_bus  out  1  ALU drives the bus.
- alu_sub  out  1  ALU mode: 1=subtract.
- mem_to_bus  out  1  store drives the bus (read).
- mem_we  out  1  store write strobe.
- mem_addr  out  ADDR_W  registered store address.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-high) forces state IDLE, every output 0, mem_addr=0, and drops any accepted or pending command. Reset asserted mid-sequence aborts it, with no done and no err.
- States: IDLE -> SETUP -> STROBE -> HOLD -> TURN -> IDLE.
- Accept: cmd_valid && cmd_ready in cycle T. cmd_op and cmd_addr are captured, and mem_addr updates at T+1.
- Driver per op:
  - LDA, LDB: mem_to_bus.
  - STA: a_to_bus.
  - STB: b_to_bus.
  - ADD_ST, SUB_ST: alu_to_bus.
- Strobe per op:
  - LDA: load_A.
  - LDB: load_B.
  - All stores: mem_we.
- SETUP (1 cycle, T+1): driver enable asserted, strobe low.
- STROBE (STROBE_CYCLES cycles): driver enable held, strobe high.
- HOLD (1 cycle): driver enable held, strobe low, so data is held past the falling edge of the latch enable.
- TURN (TURN_CYCLES cycles): all drivers and strobes low. done pulses on the last TURN cycle.
- Busy time per command is 2+STROBE_CYCLES+TURN_CYCLES clocks; with defaults, done occurs at T+4.
- alu_sub is 1 from SETUP through HOLD only for SUB_ST; it is 0 at all other times.
- Exclusivity: a_to_bus, b_to_bus, alu_to_bus and mem_to_bus are mutually exclusive (one-hot or zero) every cycle. load_A and load_B are never high while their own register drives the bus.
- Illegal op (6, 7): accepted normally. err pulses at T+1, there are no driver or strobe outputs, the state returns to IDLE at T+1, and done is not asserted.
- cmd_ready (base build) = state==IDLE. The next accept is possible in the cycle after done.
- cmd_valid while busy has no effect; the command stays stalled at the source.
- Counters load STROBE_CYCLES-1 and TURN_CYCLES-1 and count down to 0. A value of 1 therefore means a single cycle.

Optional Feature:
- Macro: SSEM_SEQ_PREFETCH_EN.
- Enabled: one-entry command buffer. cmd_ready = !buffer_full, so one command can be accepted while a sequence runs. On the done cycle, a buffered command moves straight to SETUP in the next cycle, skipping IDLE. The TURN cycles are still always inserted. Reset clears the buffer.
- Disabled: no buffer, and cmd_ready is high only in IDLE.

Decomposition:
- Package ssem_seq_pkg holds:
  - the op code constants (OP_LDA..OP_SUB_ST);
  - the state encoding (ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_TURN);
  - the driver-select encoding (DRV_NONE, DRV_A, DRV_B, DRV_ALU, DRV_MEM).
- One sub-module, ssem_seq_decode: combinational op -> {driver select, strobe select, alu_sub, illegal}. The FSM and counters stay in the top module.

Test Plan:
- Reset then LDA addr=5 at T (defaults) -> mem_addr=5 at T+1; mem_to_bus high T+1..T+3; load_A high only at T+2; done at T+4; cmd_ready high at T+5.
- SUB_ST addr=31 with STROBE_CYCLES=3, TURN_CYCLES=2 -> alu_to_bus and alu_sub high T+1..T+5; mem_we high T+2..T+4; no drivers T+6..T+7; done at T+7.
- Back-to-back STA then STB with cmd_valid held -> a_to_bus and b_to_bus never high in the same cycle, with at least one cycle of all drivers low between them. In the prefetch build, the second SETUP occurs the cycle after the first done.
- cmd_op=6 -> err pulse at T+1; every strobe and driver stays 0; no done; cmd_ready high at T+1.
- Reset asserted during STROBE of LDB -> load_B and mem_to_bus drop to 0 without waiting for a clock edge; no done; next command runs normally.
- Random legal ops for 10k cycles -> exclusivity assertion holds every cycle; done count equals accepted legal command count.
